// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out one
// byte LSB first with odd parity and stop, then check the device ack.
// Ports: clk/rstn; ps2_clk_in/ps2_data_in raw pins; tx_valid/tx_ready/tx_data
// byte handshake; ps2_clk_oe/ps2_data_oe open-drain pull-downs; busy,
// tx_done/tx_err pulses, err_code (01 start, 10 bit, 11 no ack).
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int START_TIMEOUT  = 1500000,
  parameter int BIT_TIMEOUT    = 200000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_START,
    S_BITS,
    S_ACK,
    S_RELEASE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [20:0] INH_LAST =
    21'(INHIBIT_CYCLES - 1);
  localparam logic [20:0] START_TO =
    21'(START_TIMEOUT);
  localparam logic [20:0] BIT_TO =
    21'(BIT_TIMEOUT);
  localparam logic [20:0] TMR_MAX = '1;

  function automatic logic maj3(
    input logic [2:0] v
  );
    return (v[0] & v[1]) |
           (v[0] & v[2]) |
           (v[1] & v[2]);
  endfunction

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic [2:0] clk_hist;
  logic [2:0] data_hist;
  logic       clk_filt;
  logic       data_filt;
  logic       clk_prev;
  logic       clk_fall;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_hist  <= 3'b111;
      data_hist <= 3'b111;
      clk_filt  <= 1'b1;
      data_filt <= 1'b1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_hist  <= {clk_hist[1:0], clk_sync[1]};
      data_hist <= {data_hist[1:0], data_sync[1]};
      clk_filt  <= maj3(clk_hist);
      data_filt <= maj3(data_hist);
      clk_prev  <= clk_filt;
    end
  end

  assign clk_fall = clk_prev & ~clk_filt;

  state_t      state_q, state_d;
  logic [9:0]  frame_q, frame_d;
  logic [3:0]  idx_q, idx_d;
  logic        drv_q, drv_d;
  logic [1:0]  err_q, err_d;
  logic [20:0] tmr_q, tmr_d;
  logic        tmr_clr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      idx_q   <= '0;
      drv_q   <= 1'b1;
      err_q   <= 2'b00;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      drv_q   <= drv_d;
      err_q   <= err_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    idx_d       = idx_q;
    drv_d       = drv_q;
    err_d       = err_q;
    tmr_clr     = 1'b0;
    tx_ready    = 1'b0;
    tx_done     = 1'b0;
    tx_err      = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          // frame = {stop, odd parity, data}
          frame_d = {1'b1, ~^tx_data, tx_data};
          err_d   = 2'b00;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (tmr_q >= INH_LAST)
          state_d = S_REQ;
      end
      S_REQ: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        idx_d       = 4'd0;
        state_d     = S_START;
      end
      S_START: begin
        ps2_data_oe = 1'b1;
        if (clk_fall) begin
          drv_d   = frame_q[0];
          idx_d   = 4'd1;
          state_d = S_BITS;
        end else if (tmr_q >= START_TO) begin
          err_d   = 2'b01;
          state_d = S_ERR;
        end
      end
      S_BITS: begin
        ps2_data_oe = ~drv_q;
        if (clk_fall) begin
          drv_d   = frame_q[idx_q];
          tmr_clr = 1'b1;
          if (idx_q == 4'd9)
            state_d = S_ACK;
          else
            idx_d = idx_q + 4'd1;
        end else if (tmr_q >= BIT_TO) begin
          err_d   = 2'b10;
          state_d = S_ERR;
        end
      end
      S_ACK: begin
        if (clk_fall) begin
          if (data_filt) begin
            err_d   = 2'b11;
            state_d = S_ERR;
          end else begin
            state_d = S_RELEASE;
          end
        end else if (tmr_q >= BIT_TO) begin
          err_d   = 2'b10;
          state_d = S_ERR;
        end
      end
      S_RELEASE: begin
        if (clk_filt && data_filt) begin
          state_d = S_DONE;
        end else if (tmr_q >= BIT_TO) begin
          err_d   = 2'b10;
          state_d = S_ERR;
        end
      end
      S_DONE: begin
        tx_done = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        tx_err  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // timer restarts on every state entry and on each bit edge
  always_comb begin
    if ((state_d != state_q) || tmr_clr)
      tmr_d = '0;
    else if (tmr_q == TMR_MAX)
      tmr_d = tmr_q;
    else
      tmr_d = tmr_q + 21'd1;
  end

  assign busy     = ~tx_ready;
  assign err_code = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a wired-AND PS/2 device model.
// Short timing parameters keep the run small.
module tb_ps2_host_tx;

  localparam int INH = 100;
  localparam int STO = 2000;
  localparam int BTO = 400;
  localparam int HP  = 40;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       tx_ready;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_err;
  logic [1:0] err_code;

  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT(STO),
    .BIT_TIMEOUT(BTO)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy(busy),
    .tx_done(tx_done),
    .tx_err(tx_err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_done = 0;
  int n_err = 0;
  int n_both = 0;
  int n_acc = 0;

  always @(negedge clk) begin
    if (tx_done) n_done++;
    if (tx_err) n_err++;
    if (tx_done && tx_err) n_both++;
  end

  always @(posedge clk)
    if (rstn && tx_valid && tx_ready) n_acc++;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    chk("ready_pre", 32'(tx_ready), 1);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("ready_post", 32'(tx_ready), 0);
    chk("busy_post", 32'(busy), 1);
  endtask

  task automatic wait_req(output int cnt);
    cnt = 0;
    for (int i = 0; i < INH + 50; i++) begin
      if (ps2_data_oe) break;
      if (ps2_clk_oe) cnt++;
      @(negedge clk);
    end
    chk("req_seen", 32'(ps2_data_oe), 1);
  endtask

  task automatic dev_run(
    input  int         n,
    input  logic       ack,
    output logic [9:0] bits
  );
    int w;
    w = 0;
    bits = '1;
    while (!(ps2_clk_in && !ps2_data_in) &&
           w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("rts_seen", 32'(w < 50), 1);
    repeat (HP) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      if (k == 10) begin
        dev_data = ack;
        repeat (5) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (HP) @(negedge clk);
      if (k < 10) bits[k] = ps2_data_in;
      dev_clk = 1'b1;
      repeat (HP) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_end(input int base);
    int w;
    w = 0;
    while ((n_done + n_err) <= base &&
           w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk("end_seen", 32'(w < 5000), 1);
    repeat (2) @(negedge clk);
    chk("ready_end", 32'(tx_ready), 1);
  endtask

  task automatic chk_bits(
    input logic [9:0] got,
    input logic [7:0] b,
    input logic       par
  );
    logic [9:0] exp;
    exp = {1'b1, par, b};
    for (int k = 0; k < 10; k++)
      chk($sformatf("bit%0d_%0h", k, b),
          32'(got[k]), 32'(exp[k]));
  endtask

  task automatic good_frame(
    input logic [7:0] b,
    input logic       par
  );
    int d0, e0, cnt;
    logic [9:0] bits;
    d0 = n_done;
    e0 = n_err;
    send(b);
    wait_req(cnt);
    chk("inhibit_len", 32'(cnt), 32'(INH));
    chk("req_clk_oe", 32'(ps2_clk_oe), 1);
    @(negedge clk);
    chk("start_clk_oe", 32'(ps2_clk_oe), 0);
    chk("start_data_oe", 32'(ps2_data_oe), 1);
    dev_run(11, 1'b0, bits);
    chk_bits(bits, b, par);
    wait_end(d0 + e0);
    chk("done_cnt", 32'(n_done - d0), 1);
    chk("err_cnt", 32'(n_err - e0), 0);
    chk("code_ok", 32'(err_code), 0);
  endtask

  initial begin
    int cnt, d0, e0, a0;
    logic [9:0] bits;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(tx_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 0);
    chk("rst_data_oe", 32'(ps2_data_oe), 0);
    chk("rst_done", 32'(tx_done), 0);
    chk("rst_err", 32'(tx_err), 0);
    chk("rst_code", 32'(err_code), 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    good_frame(8'hED, 1'b1);
    good_frame(8'h07, 1'b0);
    good_frame(8'h00, 1'b1);

    // device never clocks
    d0 = n_done;
    send(8'h55);
    wait_req(cnt);
    cnt = 0;
    for (int i = 0; i < STO + 50; i++) begin
      @(negedge clk);
      cnt++;
      if (tx_err) break;
    end
    chk("sto_err", 32'(tx_err), 1);
    chk("sto_time", 32'(cnt), 32'(STO + 2));
    chk("sto_code", 32'(err_code), 1);
    chk("sto_clk_oe", 32'(ps2_clk_oe), 0);
    chk("sto_data_oe", 32'(ps2_data_oe), 0);
    chk("sto_nodone", 32'(tx_done), 0);
    @(negedge clk);
    chk("sto_ready", 32'(tx_ready), 1);
    chk("sto_done_cnt", 32'(n_done - d0), 0);

    // device stalls after edge 5
    d0 = n_done;
    e0 = n_err;
    send(8'hA5);
    wait_req(cnt);
    dev_run(5, 1'b1, bits);
    wait_end(d0 + e0);
    chk("bto_err_cnt", 32'(n_err - e0), 1);
    chk("bto_done_cnt", 32'(n_done - d0), 0);
    chk("bto_code", 32'(err_code), 2);

    // no ack
    d0 = n_done;
    e0 = n_err;
    send(8'h5A);
    wait_req(cnt);
    dev_run(11, 1'b1, bits);
    chk_bits(bits, 8'h5A, 1'b1);
    wait_end(d0 + e0);
    chk("nak_err_cnt", 32'(n_err - e0), 1);
    chk("nak_done_cnt", 32'(n_done - d0), 0);
    chk("nak_code", 32'(err_code), 3);

    // reset while driving data[1]=0
    send(8'h3C);
    wait_req(cnt);
    dev_run(2, 1'b1, bits);
    chk("mid_data_oe", 32'(ps2_data_oe), 1);
    d0 = n_done;
    e0 = n_err;
    #2 rstn = 1'b0;
    #1;
    chk("arst_clk_oe", 32'(ps2_clk_oe), 0);
    chk("arst_data_oe", 32'(ps2_data_oe), 0);
    chk("arst_ready", 32'(tx_ready), 1);
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("arst_ready2", 32'(tx_ready), 1);
    chk("arst_code", 32'(err_code), 0);
    chk("arst_pulses",
        32'((n_done - d0) + (n_err - e0)), 0);

    good_frame(8'hFF, 1'b1);

    // tx_valid held high across a transfer
    a0 = n_acc;
    d0 = n_done;
    tx_valid = 1'b1;
    tx_data  = 8'h81;
    @(negedge clk);
    chk("hold_busy", 32'(tx_ready), 0);
    tx_data = 8'h42;
    wait_req(cnt);
    dev_run(11, 1'b0, bits);
    chk_bits(bits, 8'h81, 1'b1);
    chk("hold_one_acc", 32'(n_acc - a0), 1);
    cnt = 0;
    while (n_acc - a0 < 2 && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    tx_valid = 1'b0;
    chk("hold_two_acc", 32'(n_acc - a0), 2);
    chk("hold_after_done",
        32'(n_done - d0), 1);
    e0 = n_err;
    d0 = n_done;
    wait_req(cnt);
    dev_run(11, 1'b0, bits);
    chk_bits(bits, 8'h42, 1'b1);
    wait_end(d0 + e0);
    chk("hold2_done", 32'(n_done - d0), 1);
    chk("hold_acc_end", 32'(n_acc - a0), 2);

    chk("never_both", 32'(n_both), 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED (set LEDs) followed by an LED mask, or 0xFF (reset).
- Sits beside the existing PS/2 receive path on the same PS2_CLK/PS2_DATA pins.
- Drives both lines open-drain through output-enables. Top level wiring: pin = oe ? 1'b0 : 1'bz.
- Device responses (0xFA ack byte etc.) come back through the existing receiver. `busy` tells that path to ignore line activity caused by this transfer.

Parameters:
- INHIBIT_CYCLES, 10000: clock-inhibit hold before request (100 us at 100 MHz).
- START_TIMEOUT, 1500000: max cycles from request to first device falling edge (15 ms).
- BIT_TIMEOUT, 200000: max cycles between consecutive device falling edges, and for the final bus release (2 ms).

Ports:
- clk  in  1  system clock, 100 MHz
- rstn  in  1  asynchronous active-low reset
- ps2_clk_in  in  1  raw PS2_CLK pin level (asynchronous)
- ps2_data_in  in  1  raw PS2_DATA pin level (asynchronous)
- tx_valid  in  1  request to send tx_data
- tx_data  in  8  command byte
- tx_ready  out  1  high when idle; byte accepted on tx_valid&tx_ready
- ps2_clk_oe  out  1  1 = pull PS2_CLK low
- ps2_data_oe  out  1  1 = pull PS2_DATA low
- busy  out  1  equals ~tx_ready
- tx_done  out  1  one-cycle pulse: byte sent and device acked
- tx_err  out  1  one-cycle pulse: transfer failed
- err_code  out  2  valid with tx_err; holds until next accept. 01 = start timeout, 10 = bit timeout, 11 = no ack

Behaviour:
- Reset (async, immediate):
  - state IDLE; ps2_clk_oe = ps2_data_oe = 0 (both lines released).
  - tx_ready = 1, busy = 0, tx_done = tx_err = 0, err_code = 00.
  - Synchronizers preset to 1.
  - Reset mid-transfer abandons the frame with no pulse.
- Input conditioning:
  - Each input passes a 2-FF synchronizer, then a 3-sample majority filter.
  - Falling edge = filtered previous 1, current 0. Single-cycle detect.
- On accept:
  - Latch tx_data and parity = ~^tx_data (odd).
  - Clear err_code; the timeout counter restarts at every state entry.
- IDLE: oe's 0, tx_ready = 1. Accept goes to INHIBIT on the next cycle.
- INHIBIT:
  - clk_oe = 1 for exactly INHIBIT_CYCLES cycles, then REQ.
- REQ (1 cycle):
  - clk_oe = 1, data_oe = 1, so data goes low before clock release.
  - Then START with bit index = 0.
- START:
  - clk_oe = 0, data_oe = 1 (start bit).
  - Timer ≥ START_TIMEOUT: ERR with code 01.
  - First falling edge: drive bit 0 and go to BITS.
- BITS: each falling edge drives the next bit; frame is LSB first.
  - Edges 1–8 drive data[0..7]; edge 9 drives parity; edge 10 drives stop (data_oe = 0).
  - Driving bit b means data_oe = ~b.
  - Gap ≥ BIT_TIMEOUT: ERR with code 10.
  - After edge 10: ACK.
- ACK:
  - Edge 11: sample filtered data. 0 goes to RELEASE; 1 goes to ERR with code 11.
  - Timeout: code 10.
- RELEASE:
  - Wait until filtered clk and data are both 1, then DONE.
  - Timeout: code 10.
- DONE (1 cycle): tx_done = 1, then IDLE.
- ERR (1 cycle): tx_err = 1, both oe's 0, then IDLE.
- Priority: if a falling edge and a timeout coincide, the edge wins.
- tx_valid outside IDLE is ignored; there is no queueing. tx_data is don't-care after accept.
- Timeout counter: 21 bits, saturating.
- tx_done and tx_err are never high together.
- Latency from accept to data low is INHIBIT_CYCLES + 1 cycles.

Test Plan:
- Send 0xED with a device model clocking at 40 us/half-period that acks on edge 11:
  - clk_oe high for 10000 cycles, then data_oe rises one cycle before clk_oe falls.
  - Line bits on edges 1–10: 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once, err_code stays 00.
- Send 0x07: parity bit 0. Send 0x00: parity bit 1. Both complete with tx_done.
- Device never clocks: tx_err at START_TIMEOUT after REQ; err_code = 01; both oe = 0; tx_ready = 1 the cycle after.
- Device stops after edge 5: tx_err after BIT_TIMEOUT, err_code = 10.
- Device leaves data high at edge 11: tx_err, err_code = 11.
- Both error paths: tx_done never asserts.
- rstn low during BITS: both oe's drop combinationally (async). After release: tx_ready = 1, no pulses.
- Then a 0xFF send completes normally.
- tx_valid held high through a transfer: exactly one accept. A second byte is accepted only after tx_done/tx_err and the return to IDLE.
